feature_bram_writer: RTL and testbench
======================================

// Module: feature_bram_writer
// PURPOSE
// - Transmit side of the input-feature BRAM load port. Accepts a serial signed pixel stream and packs
//   KERNEL_SIZE pixels per word. Writes each word to consecutive BRAM addresses and pulses load_done.
// - Sits between the pixel source and the port-1 write side of the feature dual_port_ram.
// - Its outputs map 1:1 onto bram_select_en / bram_addr_f / bram_data_f / load_down of lenet5.
// PARAMETERS
// - IN_WIDTH     8   pixel width (signed, two's complement)
// - KERNEL_SIZE  5   pixels packed per BRAM word
// - IMAGE        32  address space; address width AW = clogb2(IMAGE) (=6 by default)
// - NUM_WORDS    32  words written per load, 1..2**AW
// PORTS
// - clk         in   1                clock; all logic rising-edge
// - rst         in   1                synchronous reset, active-low
// - start       in   1                begin a load; sampled only in IDLE
// - pix_valid   in   1                pix_data / pix_last valid this cycle
// - pix_data    in   IN_WIDTH         next pixel
// - pix_last    in   1                final pixel of the stream; pads and ends the load early
// - pix_ready   out  1                writer accepts a pixel this cycle
// - bram_we     out  1                write strobe (-> bram_select_en)
// - bram_addr   out  AW               write address (-> bram_addr_f)
// - bram_data   out  KERNEL_SIZE*IN_WIDTH  packed word (-> bram_data_f)
// - busy        out  1                high from start accept until load_done
// - load_done   out  1                one-cycle pulse after final write (-> load_down)
// BEHAVIOUR
// - Reset (rst==0 at a clk edge): state IDLE; pix_ready, bram_we, busy, load_done = 0.
//   Also clears bram_addr, bram_data, the lane counter and the word counter.
//   Reset mid-load discards the partial word with no write.
// - FSM states:
//   - IDLE -> FILL on start: busy=1, addr=0, lane=0.
//   - FILL: pix_ready=1. An accept (valid&&ready) stores the pixel in lane `lane`.
//     Lane 0 occupies bits [IN_WIDTH-1:0] (LSB first). Then lane++.
//   - On accepting lane KERNEL_SIZE-1, or any lane with pix_last=1:
//     - Unfilled higher lanes are zeroed.
//     - In the next cycle the word is presented on bram_data with bram_we=1 and bram_addr = word index.
//     - The transfer stays in FILL, so there is no stall and pix_ready stays 1.
//   - After the write strobe cycle, addr increments. If NUM_WORDS words have been written,
//     or the write came from pix_last: go to DONE and drop pix_ready the cycle after the strobe.
//   - DONE: load_done=1 for exactly 1 cycle, busy drops in the same cycle, then -> IDLE.
// - Latency: bram_we asserts 1 cycle after the accept that completes the word.
// - Sustained rate is 1 pixel/cycle.
// - bram_data and bram_addr hold their value when bram_we=0.
// - Boundaries:
//   - start while busy is ignored.
//   - pix_valid in IDLE/DONE is not accepted (pix_ready=0).
//   - pix_last on lane KERNEL_SIZE-1 of word NUM_WORDS-1 gives a single normal write then DONE.
//   - Address never wraps: at most NUM_WORDS writes per load.
//   - pix_last with lane==0 of a fresh word still writes that word: pixel in lane 0, rest zero.
//   - start asserted in the same cycle as load_done is ignored. A new load needs start in IDLE.
// - Arithmetic: lane counter clogb2(KERNEL_SIZE) bits; word counter AW+1 bits so that
//   NUM_WORDS=2**AW terminates.
// STRUCTURE
// - Shared package: clogb2 function, FSM state encoding (IDLE/FILL/DONE), default IN_WIDTH/KERNEL_SIZE.
// - One sub-module: pixel_lane_packer.
//   - Lane register, lane counter, zero-fill on last.
//   - Emits word_valid/word.
// - FSM and address counter live in this top.
// TESTING
// - Full load, 32x5=160 pixels, pix_valid held high:
//   - 32 strobes at addr 0..31, one every 5 cycles.
//   - Word 0 = {p4,p3,p2,p1,p0}.
//   - load_done pulses 1 cycle after the addr-31 strobe.
// - Bubbles (pix_valid toggling 1010...) on pixels 0x01..0x05:
//   - One strobe, bram_data=40'h0504030201, addr=0.
//   - No pixel is dropped or duplicated.
// - pix_last on the 3rd pixel of word 2 (pixels 0x81,0x7F,0xFF):
//   - Strobe at addr 2 with data=40'h0000FF7F81.
//   - Next cycle load_done=1, then busy=0.
// - Reset mid-load, rst=0 after 7 pixels:
//   - No further strobes; all outputs 0 next cycle.
//   - A fresh start then writes from addr 0.
// - start pulsed during FILL and in the load_done cycle: ignored. Addresses continue unchanged.
// - NUM_WORDS=64 (AW=6): the 64th strobe is at addr 63, followed by load_done and no wrap to addr 0.

Source files
------------

// File: rtl/feature_bram_writer_pkg.sv
// Shared types and helpers for the feature BRAM write port: state encoding,
// default pixel geometry and the bit-width helper used to size counters.
package feature_bram_writer_pkg;

    localparam int DEF_IN_WIDTH    = 8;
    localparam int DEF_KERNEL_SIZE = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of bits needed to hold the value `depth` itself (32 -> 6, 5 -> 3).
    function automatic int clogb2(input int depth);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if (depth >= (1 << i)) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/feature_bram_writer_pixel_lane_packer.sv
// Packs a serial pixel stream into KERNEL_SIZE-lane words, lane 0 in the LSBs.
// A word completes on the last lane or on pix_last; unfilled lanes read as zero.
module pixel_lane_packer
    import feature_bram_writer_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            accept,
    input  logic [IN_WIDTH-1:0]             pix_data,
    input  logic                            pix_last,
    output logic                            word_valid,
    output logic [KERNEL_SIZE*IN_WIDTH-1:0] word
);

    localparam int KW = KERNEL_SIZE * IN_WIDTH;
    localparam int LW = clogb2(KERNEL_SIZE);
    localparam logic [LW-1:0] LAST_LANE = LW'(KERNEL_SIZE - 1);

    logic [LW-1:0] r_lane;
    logic [KW-1:0] r_lanes;
    logic [KW-1:0] w_pix_placed;

    always_comb begin
        w_pix_placed = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (r_lane == LW'(i)) begin
                w_pix_placed[i*IN_WIDTH +: IN_WIDTH] = pix_data;
            end
        end
    end

    // Lanes above r_lane are always zero in r_lanes, so OR-ing in the new pixel
    // yields the zero-filled word for an early pix_last as well.
    assign word_valid = accept && (pix_last || (r_lane == LAST_LANE));
    assign word       = r_lanes | w_pix_placed;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_lane  <= '0;
            r_lanes <= '0;
        end else if (accept) begin
            if (word_valid) begin
                r_lane  <= '0;
                r_lanes <= '0;
            end else begin
                r_lane  <= r_lane + LW'(1);
                r_lanes <= word;
            end
        end
    end

endmodule

// File: rtl/feature_bram_writer.sv
// Feature BRAM load port: packs the pixel stream into words, writes them to
// consecutive addresses from 0, and pulses load_done when the load ends.
module feature_bram_writer
    import feature_bram_writer_pkg::*;
#(
    parameter int IN_WIDTH    = DEF_IN_WIDTH,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int IMAGE       = 32,
    parameter int NUM_WORDS   = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            pix_valid,
    input  logic [IN_WIDTH-1:0]             pix_data,
    input  logic                            pix_last,
    output logic                            pix_ready,
    output logic                            bram_we,
    output logic [clogb2(IMAGE)-1:0]        bram_addr,
    output logic [KERNEL_SIZE*IN_WIDTH-1:0] bram_data,
    output logic                            busy,
    output logic                            load_done
);

    localparam int AW  = clogb2(IMAGE);
    localparam int AW1 = AW + 1;
    localparam int DW  = KERNEL_SIZE * IN_WIDTH;
    localparam logic [AW:0] LAST_WORD = AW1'(NUM_WORDS - 1);

    state_t          r_state;
    logic [AW:0]     r_word_cnt;
    logic            r_final;
    logic            r_pix_ready;
    logic            r_bram_we;
    logic [AW-1:0]   r_bram_addr;
    logic [DW-1:0]   r_bram_data;
    logic            r_busy;
    logic            r_load_done;

    logic            w_accept;
    logic            w_clear;
    logic            w_word_valid;
    logic [DW-1:0]   w_word;

    assign w_accept = pix_valid && r_pix_ready;
    assign w_clear  = (r_state != ST_FILL);

    pixel_lane_packer #(
        .IN_WIDTH    (IN_WIDTH),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .accept     (w_accept),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    // r_final marks the strobe that ends the load; the FSM leaves FILL right after it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_word_cnt  <= '0;
            r_final     <= 1'b0;
            r_pix_ready <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_data <= '0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_bram_we   <= 1'b0;
            r_load_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_FILL;
                        r_busy      <= 1'b1;
                        r_pix_ready <= 1'b1;
                        r_word_cnt  <= '0;
                        r_final     <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (r_bram_we && r_final) begin
                        r_state     <= ST_DONE;
                        r_pix_ready <= 1'b0;
                        r_busy      <= 1'b0;
                        r_load_done <= 1'b1;
                    end else if (w_word_valid) begin
                        r_bram_we   <= 1'b1;
                        r_bram_addr <= r_word_cnt[AW-1:0];
                        r_bram_data <= w_word;
                        r_word_cnt  <= r_word_cnt + AW1'(1);
                        r_final     <= pix_last || (r_word_cnt == LAST_WORD);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pix_ready = r_pix_ready;
    assign bram_we   = r_bram_we;
    assign bram_addr = r_bram_addr;
    assign bram_data = r_bram_data;
    assign busy      = r_busy;
    assign load_done = r_load_done;

endmodule

// File: tb/tb_feature_bram_writer.sv
// Bench for feature_bram_writer: a 32-word instance driven by table vectors and
// hand sequences, plus a 64-word instance for the full-address-space load.
module tb_feature_bram_writer;

    localparam int W  = 8;
    localparam int K  = 5;
    localparam int AW = 6;
    localparam int DW = K * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          sel = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [W-1:0]  pix_data = '0;
    logic          pix_last = 1'b0;

    logic          start_a, valid_a, ready_a, we_a, busy_a, done_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] data_a;
    logic          start_b, valid_b, ready_b, we_b, busy_b, done_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;
    logic          cur_ready;

    assign start_a   = start & ~sel;
    assign valid_a   = pix_valid & ~sel;
    assign start_b   = start & sel;
    assign valid_b   = pix_valid & sel;
    assign cur_ready = sel ? ready_b : ready_a;

    feature_bram_writer #(.IN_WIDTH(W), .KERNEL_SIZE(K), .IMAGE(32), .NUM_WORDS(32)) dut (
        .clk(clk), .rst(rst), .start(start_a), .pix_valid(valid_a), .pix_data(pix_data),
        .pix_last(pix_last), .pix_ready(ready_a), .bram_we(we_a), .bram_addr(addr_a),
        .bram_data(data_a), .busy(busy_a), .load_done(done_a)
    );

    feature_bram_writer #(.IN_WIDTH(W), .KERNEL_SIZE(K), .IMAGE(32), .NUM_WORDS(64)) dut64 (
        .clk(clk), .rst(rst), .start(start_b), .pix_valid(valid_b), .pix_data(pix_data),
        .pix_last(pix_last), .pix_ready(ready_b), .bram_we(we_b), .bram_addr(addr_b),
        .bram_data(data_b), .busy(busy_b), .load_done(done_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt_a = 0, done_cnt_a = 0, last_we_a = 0;
    int done_cnt_b = 0, last_we_b = 0;
    logic chk_gap = 1'b0;
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_b_q[$];
    logic [AW+DW-1:0] e_a, e_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard for the 32-word instance: every strobe must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            if (we_a) begin
                if (exp_q.size() == 0) begin
                    check("a_unexpected_we", 64'(addr_a), 64'hFFFF);
                end else begin
                    e_a = exp_q.pop_front();
                    check("a_we_addr", 64'(addr_a), 64'(e_a[DW +: AW]));
                    check("a_we_data", 64'(data_a), 64'(e_a[DW-1:0]));
                end
                if (chk_gap && we_cnt_a > 0) check("a_we_gap", 64'(cyc - last_we_a), 64'd5);
                last_we_a = cyc;
                we_cnt_a++;
            end
            if (done_a) begin
                check("a_done_latency", 64'(cyc - last_we_a), 64'd1);
                check("a_done_busy", 64'(busy_a), 64'd0);
                done_cnt_a++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (we_b) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected_we", 64'(addr_b), 64'hFFFF);
                end else begin
                    e_b = exp_b_q.pop_front();
                    check("b_we_addr", 64'(addr_b), 64'(e_b[DW +: AW]));
                    check("b_we_data", 64'(data_b), 64'(e_b[DW-1:0]));
                end
                last_we_b = cyc;
            end
            if (done_b) begin
                check("b_done_latency", 64'(cyc - last_we_b), 64'd1);
                done_cnt_b++;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        int t;
        t = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        while (!cur_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("send_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic wait_done_a(input int target);
        int t;
        t = 0;
        while (done_cnt_a < target && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("a_done_seen", 64'(done_cnt_a >= target), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic push_a(input int addr, input logic [DW-1:0] d);
        exp_q.push_back({AW'(addr), d});
    endtask

    function automatic logic [W-1:0] pat(input int i);
        return W'(i * 7 + 3);
    endfunction

    typedef struct packed {
        logic [2:0]    n;
        logic          bub;
        logic [DW-1:0] px;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t tbl[5];
    logic [DW-1:0] d;

    initial begin
        tbl[0] = '{n: 3'd5, bub: 1'b1, px: 40'h0504030201, exp: 40'h0504030201};
        tbl[1] = '{n: 3'd1, bub: 1'b0, px: 40'h0000000080, exp: 40'h0000000080};
        tbl[2] = '{n: 3'd3, bub: 1'b0, px: 40'h0000FF7F81, exp: 40'h0000FF7F81};
        tbl[3] = '{n: 3'd4, bub: 1'b1, px: 40'h00DDCCBBAA, exp: 40'h00DDCCBBAA};
        tbl[4] = '{n: 3'd2, bub: 1'b0, px: 40'h00000000FF, exp: 40'h00000000FF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_ready", 64'(ready_a), 64'd0);
        check("rst_bram_we", 64'(we_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_load_done", 64'(done_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_data", 64'(data_a), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single-word loads ending in pix_last, optionally with bubbles; junk offered in IDLE first
        for (int v = 0; v < 5; v++) begin
            pix_valid = 1'b1;
            pix_data  = 8'hEE;
            repeat (2) @(posedge clk);
            #1;
            pix_valid = 1'b0;
            check("idle_not_ready", 64'(ready_a), 64'd0);
            push_a(0, tbl[v].exp);
            pulse_start();
            check("tbl_busy", 64'(busy_a), 64'd1);
            for (int i = 0; i < int'(tbl[v].n); i++) begin
                send(tbl[v].px[i*W +: W], (i == int'(tbl[v].n) - 1));
                if (tbl[v].bub) begin
                    @(posedge clk); #1;
                end
            end
            wait_done_a(v + 1);
            check("tbl_drained", 64'(exp_q.size()), 64'd0);
            check("tbl_idle_ready", 64'(ready_a), 64'd0);
        end

        // Full 32-word load, pix_valid held high
        chk_gap = 1'b1;
        we_cnt_a = 0;
        for (int w = 0; w < 32; w++) begin
            for (int l = 0; l < K; l++) d[l*W +: W] = pat(w * K + l);
            push_a(w, d);
        end
        pulse_start();
        for (int i = 0; i < 32 * K; i++) send(pat(i), 1'b0);
        wait_done_a(6);
        chk_gap = 1'b0;
        check("full_we_count", 64'(we_cnt_a), 64'd32);
        check("full_drained", 64'(exp_q.size()), 64'd0);
        check("full_addr_hold", 64'(addr_a), 64'd31);
        check("full_busy_low", 64'(busy_a), 64'd0);

        // pix_last on the 3rd pixel of word 2
        for (int w = 0; w < 2; w++) begin
            for (int l = 0; l < K; l++) d[l*W +: W] = pat(100 + w * K + l);
            push_a(w, d);
        end
        push_a(2, 40'h0000FF7F81);
        pulse_start();
        for (int i = 0; i < 2 * K; i++) send(pat(100 + i), 1'b0);
        send(8'h81, 1'b0);
        send(8'h7F, 1'b0);
        send(8'hFF, 1'b1);
        check("last_strobe_now", 64'(we_a), 64'd1);
        @(posedge clk); #1;
        check("last_done_pulse", 64'(done_a), 64'd1);
        check("last_busy_low", 64'(busy_a), 64'd0);
        wait_done_a(7);
        check("last_drained", 64'(exp_q.size()), 64'd0);

        // Reset after 7 pixels: word 0 written, partial word 1 discarded
        push_a(0, {pat(204), pat(203), pat(202), pat(201), pat(200)});
        pulse_start();
        for (int i = 0; i < 7; i++) send(pat(200 + i), 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", 64'(ready_a), 64'd0);
        check("mid_rst_we", 64'(we_a), 64'd0);
        check("mid_rst_busy", 64'(busy_a), 64'd0);
        check("mid_rst_addr", 64'(addr_a), 64'd0);
        check("mid_rst_data", 64'(data_a), 64'd0);
        rst = 1'b1;
        we_cnt_a = 0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_we", 64'(we_cnt_a), 64'd0);
        push_a(0, 40'h0000003322);
        pulse_start();
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        wait_done_a(8);
        check("mid_rst_drained", 64'(exp_q.size()), 64'd0);

        // start during FILL and in the load_done cycle is ignored
        push_a(0, 40'h1514131211);
        push_a(1, 40'h2524232221);
        pulse_start();
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        start = 1'b1;
        send(8'h13, 1'b0);
        start = 1'b0;
        send(8'h14, 1'b0);
        send(8'h15, 1'b0);
        start = 1'b1;
        send(8'h21, 1'b0);
        start = 1'b0;
        send(8'h22, 1'b0);
        send(8'h23, 1'b0);
        send(8'h24, 1'b0);
        send(8'h25, 1'b1);
        @(posedge clk); #1;
        check("ign_done_pulse", 64'(done_a), 64'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("ign_busy", 64'(busy_a), 64'd0);
        check("ign_ready", 64'(ready_a), 64'd0);
        check("ign_drained", 64'(exp_q.size()), 64'd0);
        check("ign_done_cnt", 64'(done_cnt_a), 64'd9);

        // 64-word instance: fills the whole address space without wrapping
        sel = 1'b1;
        for (int w = 0; w < 64; w++) begin
            for (int l = 0; l < K; l++) d[l*W +: W] = W'(w * K + l);
            exp_b_q.push_back({AW'(w), d});
        end
        pulse_start();
        for (int i = 0; i < 64 * K; i++) send(W'(i), 1'b0);
        for (int t = 0; t < 50 && done_cnt_b == 0; t++) @(negedge clk);
        check("b_done_seen", 64'(done_cnt_b), 64'd1);
        pix_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        pix_valid = 1'b0;
        check("b_drained", 64'(exp_b_q.size()), 64'd0);
        check("b_addr_hold", 64'(addr_b), 64'd63);
        check("b_busy_low", 64'(busy_b), 64'd0);
        check("b_ready_low", 64'(ready_b), 64'd0);
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
